// File: rtl/pulse_scheduler.sv
// Frequency-sweep pulse scheduler: loads a frequency word per point, waits for
// the load to settle, then fires a burst of pulses before stepping to the next point.
module pulse_scheduler #(
  parameter int unsigned SETTLE_CYC  = 100,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [31:0] F_START,
  input  logic [31:0] F_STEP,
  input  logic [7:0]  STEP_NUM,
  input  logic [7:0]  REPEAT,
  input  logic [31:0] CODE_IN,
  input  logic [7:0]  CODE_LEN_IN,
  input  logic [15:0] PULSE_LEN_IN,
  output logic [31:0] FREQW,
  output logic        FREQW_UPDATE,
  input  logic        FREQW_UPDATE_OVER,
  output logic [31:0] CODE,
  output logic [7:0]  CODE_LEN,
  output logic [15:0] PULSE_LEN,
  output logic        GEN,
  input  logic        GEN_OVER,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  STEP_IDX
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_F_LO,
    S_WAIT_F_HI,
    S_SETTLE,
    S_FIRE,
    S_WAIT_G_LO,
    S_WAIT_G_HI,
    S_NEXT
  } state_t;

  localparam logic [31:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 32'd0 : 32'(SETTLE_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_freqw;
  logic        r_freqw_update;
  logic [31:0] r_code;
  logic [7:0]  r_code_len;
  logic [15:0] r_pulse_len;
  logic        r_gen;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_step_idx;
  logic [7:0]  r_step_num;
  logic [7:0]  r_repeat;
  logic [31:0] r_f_step;
  logic [7:0]  r_pulse_cnt;
  logic [31:0] r_settle_cnt;
  logic [23:0] r_tmo_cnt;

  logic        w_tmo_hit;
  logic        w_start_run;
  logic        w_empty_done;
  logic        w_fire;
  logic        w_tmo_err;
  logic        w_pulse_dec;
  logic        w_last_done;
  logic        w_next_pt;

  // Hit on the last cycle of the allowed window so the exit edge lands exactly at TIMEOUT_CYC.
  assign w_tmo_hit = ({1'b0, r_tmo_cnt} + 25'd1) >= {1'b0, TIMEOUT_CYC};

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_run  = 1'b0;
    w_empty_done = 1'b0;
    w_fire       = 1'b0;
    w_tmo_err    = 1'b0;
    w_pulse_dec  = 1'b0;
    w_last_done  = 1'b0;
    w_next_pt    = 1'b0;
    if (ABORT) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            if (STEP_NUM != 8'd0 && REPEAT != 8'd0) begin
              w_start_run = 1'b1;
              w_state_nxt = S_LOAD;
            end else begin
              w_empty_done = 1'b1;
            end
          end
        end
        S_LOAD: begin
          w_state_nxt = S_WAIT_F_LO;
        end
        S_WAIT_F_LO: begin
          if (!FREQW_UPDATE_OVER) begin
            w_state_nxt = S_WAIT_F_HI;
          end else if (w_tmo_hit) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT_F_HI: begin
          if (FREQW_UPDATE_OVER) begin
            w_state_nxt = (SETTLE_CYC == 0) ? S_FIRE : S_SETTLE;
          end else if (w_tmo_hit) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_state_nxt = S_FIRE;
          end
        end
        S_FIRE: begin
          if (GEN_OVER) begin
            w_fire      = 1'b1;
            w_state_nxt = S_WAIT_G_LO;
          end else if (w_tmo_hit) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT_G_LO: begin
          if (!GEN_OVER) begin
            w_state_nxt = S_WAIT_G_HI;
          end else if (w_tmo_hit) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT_G_HI: begin
          if (GEN_OVER) begin
            w_pulse_dec = 1'b1;
            w_state_nxt = (r_pulse_cnt == 8'd1) ? S_NEXT : S_FIRE;
          end else if (w_tmo_hit) begin
            w_tmo_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_NEXT: begin
          if (r_step_idx == r_step_num - 8'd1) begin
            w_last_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_next_pt   = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_freqw        <= '0;
      r_freqw_update <= 1'b0;
      r_code         <= '0;
      r_code_len     <= '0;
      r_pulse_len    <= '0;
      r_gen          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_step_idx     <= '0;
      r_step_num     <= '0;
      r_repeat       <= '0;
      r_f_step       <= '0;
      r_pulse_cnt    <= '0;
      r_settle_cnt   <= '0;
      r_tmo_cnt      <= '0;
    end else begin
      // Strobes are registered from the next state so each lines up with its state cycle.
      r_freqw_update <= (w_state_nxt == S_LOAD);
      r_gen          <= w_fire;
      r_done         <= w_empty_done | w_last_done;

      if (w_state_nxt != r_state || r_state == S_IDLE) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end

      if (r_state == S_SETTLE && w_state_nxt == S_SETTLE) begin
        r_settle_cnt <= r_settle_cnt + 32'd1;
      end else begin
        r_settle_cnt <= '0;
      end

      if (w_start_run) begin
        r_step_num  <= STEP_NUM;
        r_repeat    <= REPEAT;
        r_f_step    <= F_STEP;
        r_code      <= CODE_IN;
        r_code_len  <= CODE_LEN_IN;
        r_pulse_len <= PULSE_LEN_IN;
        r_freqw     <= F_START;
        r_step_idx  <= '0;
        r_pulse_cnt <= REPEAT;
        r_err       <= 1'b0;
        r_busy      <= 1'b1;
      end

      if (w_pulse_dec) begin
        r_pulse_cnt <= r_pulse_cnt - 8'd1;
      end

      if (w_next_pt) begin
        r_step_idx  <= r_step_idx + 8'd1;
        r_freqw     <= r_freqw + r_f_step;
        r_pulse_cnt <= r_repeat;
      end

      if (w_tmo_err) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
      end

      if (w_last_done || ABORT) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign FREQW        = r_freqw;
  assign FREQW_UPDATE = r_freqw_update;
  assign CODE         = r_code;
  assign CODE_LEN     = r_code_len;
  assign PULSE_LEN    = r_pulse_len;
  assign GEN          = r_gen;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign ERR          = r_err;
  assign STEP_IDX     = r_step_idx;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler with handshake models for the frequency
// and pulse stages (SETTLE_CYC=4, TIMEOUT_CYC=50).
module tb_pulse_scheduler;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        START;
  logic        ABORT;
  logic [31:0] F_START;
  logic [31:0] F_STEP;
  logic [7:0]  STEP_NUM;
  logic [7:0]  REPEAT;
  logic [31:0] CODE_IN;
  logic [7:0]  CODE_LEN_IN;
  logic [15:0] PULSE_LEN_IN;
  logic [31:0] FREQW;
  logic        FREQW_UPDATE;
  logic        FREQW_UPDATE_OVER = 1'b1;
  logic [31:0] CODE;
  logic [7:0]  CODE_LEN;
  logic [15:0] PULSE_LEN;
  logic        GEN;
  logic        GEN_OVER = 1'b1;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  STEP_IDX;

  pulse_scheduler #(
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(24'd50)
  ) dut (
    .CLOCK_10M        (clk),
    .RESET_N          (RESET_N),
    .START            (START),
    .ABORT            (ABORT),
    .F_START          (F_START),
    .F_STEP           (F_STEP),
    .STEP_NUM         (STEP_NUM),
    .REPEAT           (REPEAT),
    .CODE_IN          (CODE_IN),
    .CODE_LEN_IN      (CODE_LEN_IN),
    .PULSE_LEN_IN     (PULSE_LEN_IN),
    .FREQW            (FREQW),
    .FREQW_UPDATE     (FREQW_UPDATE),
    .FREQW_UPDATE_OVER(FREQW_UPDATE_OVER),
    .CODE             (CODE),
    .CODE_LEN         (CODE_LEN),
    .PULSE_LEN        (PULSE_LEN),
    .GEN              (GEN),
    .GEN_OVER         (GEN_OVER),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .ERR              (ERR),
    .STEP_IDX         (STEP_IDX)
  );

  always #50 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic        stuck_gen = 1'b0;
  int unsigned f_cnt = 0, g_cnt = 0;
  int unsigned cyc = 0, n_upd = 0, n_gen = 0, n_done = 0, n_busy = 0;
  int unsigned n_overlap = 0, n_wide = 0;
  int unsigned last_upd_cyc = 0, last_gen_cyc = 0, gap_upd_gen = 0, gap_gen_gen = 0;
  logic        pend_first = 1'b0, prev_gen = 1'b0, prev_upd = 1'b0;
  logic [31:0] fw_log [0:63];

  // Frequency stage drops its ready for 3 cycles per load; pulse stage for 5 cycles per pulse.
  always @(negedge clk) begin
    cyc++;
    if (FREQW_UPDATE) f_cnt = 3;
    else if (f_cnt != 0) f_cnt--;
    FREQW_UPDATE_OVER = (f_cnt == 0);
    if (GEN && !stuck_gen) g_cnt = 5;
    else if (g_cnt != 0) g_cnt--;
    GEN_OVER = (g_cnt == 0);
    if (FREQW_UPDATE) begin
      fw_log[n_upd % 64] = FREQW;
      n_upd++;
      last_upd_cyc = cyc;
      pend_first = 1'b1;
    end
    if (GEN) begin
      if (pend_first) gap_upd_gen = cyc - last_upd_cyc;
      else gap_gen_gen = cyc - last_gen_cyc;
      pend_first = 1'b0;
      last_gen_cyc = cyc;
      n_gen++;
    end
    if (DONE) n_done++;
    if (BUSY) n_busy++;
    if (GEN && FREQW_UPDATE) n_overlap++;
    if ((GEN && prev_gen) || (FREQW_UPDATE && prev_upd)) n_wide++;
    prev_gen = GEN;
    prev_upd = FREQW_UPDATE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned bound);
    int unsigned i = 0;
    while (!DONE && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {31'd0, DONE}, 32'd1);
  endtask

  task automatic wait_gen(input string tag, input int unsigned bound);
    int unsigned i = 0;
    while (!GEN && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {31'd0, GEN}, 32'd1);
  endtask

  int unsigned b_upd, b_gen, b_done, b_busy;

  task automatic snap();
    b_upd  = n_upd;
    b_gen  = n_gen;
    b_done = n_done;
    b_busy = n_busy;
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    F_START = 32'd0; F_STEP = 32'd0; STEP_NUM = 8'd0; REPEAT = 8'd0;
    CODE_IN = 32'd0; CODE_LEN_IN = 8'd0; PULSE_LEN_IN = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_freqw", FREQW, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_strobes", {30'd0, GEN, FREQW_UPDATE}, 32'd0);
    chk("rst_step_idx", {24'd0, STEP_IDX}, 32'd0);
    chk("rst_code", CODE, 32'd0);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);

    // Basic three-point sweep with a START retried mid-sweep and inputs disturbed.
    F_START = 32'd100; F_STEP = 32'd10; STEP_NUM = 8'd3; REPEAT = 8'd2;
    CODE_IN = 32'hA5A5_0F0F; CODE_LEN_IN = 8'd13; PULSE_LEN_IN = 16'h1234;
    snap();
    pulse_start();
    chk("s1_busy_start", {31'd0, BUSY}, 32'd1);
    chk("s1_freqw_start", FREQW, 32'd100);
    chk("s1_upd_first", {31'd0, FREQW_UPDATE}, 32'd1);
    repeat (3) @(negedge clk);
    F_START = 32'd999; F_STEP = 32'd1; STEP_NUM = 8'd9; REPEAT = 8'd9;
    CODE_IN = 32'hDEAD_BEEF; CODE_LEN_IN = 8'd1; PULSE_LEN_IN = 16'd7;
    pulse_start();
    wait_done("s1_done_seen", 1000);
    chk("s1_step_idx_last", {24'd0, STEP_IDX}, 32'd2);
    repeat (3) @(negedge clk);
    chk("s1_upd_count", n_upd - b_upd, 32'd3);
    chk("s1_gen_count", n_gen - b_gen, 32'd6);
    chk("s1_done_count", n_done - b_done, 32'd1);
    chk("s1_fw0", fw_log[b_upd % 64], 32'd100);
    chk("s1_fw1", fw_log[(b_upd + 1) % 64], 32'd110);
    chk("s1_fw2", fw_log[(b_upd + 2) % 64], 32'd120);
    chk("s1_err", {31'd0, ERR}, 32'd0);
    chk("s1_busy_end", {31'd0, BUSY}, 32'd0);
    chk("s1_code", CODE, 32'hA5A5_0F0F);
    chk("s1_code_len", {24'd0, CODE_LEN}, 32'd13);
    chk("s1_pulse_len", {16'd0, PULSE_LEN}, 32'h1234);
    chk("s1_upd_to_gen", gap_upd_gen, 32'd9);
    chk("s1_gen_to_gen", gap_gen_gen, 32'd7);

    // Frequency word wraps modulo 2^32.
    F_START = 32'hFFFF_FFF8; F_STEP = 32'd16; STEP_NUM = 8'd2; REPEAT = 8'd1;
    snap();
    pulse_start();
    wait_done("s2_done_seen", 1000);
    repeat (3) @(negedge clk);
    chk("s2_fw0", fw_log[b_upd % 64], 32'hFFFF_FFF8);
    chk("s2_fw1", fw_log[(b_upd + 1) % 64], 32'h0000_0008);
    chk("s2_gen_count", n_gen - b_gen, 32'd2);

    // Empty sweeps complete immediately without touching the stages.
    STEP_NUM = 8'd0; REPEAT = 8'd3;
    snap();
    pulse_start();
    chk("s3_done_now", {31'd0, DONE}, 32'd1);
    @(negedge clk);
    chk("s3_done_once", {31'd0, DONE}, 32'd0);
    STEP_NUM = 8'd2; REPEAT = 8'd0;
    pulse_start();
    chk("s3_rep0_done", {31'd0, DONE}, 32'd1);
    repeat (5) @(negedge clk);
    chk("s3_strobes", (n_upd - b_upd) + (n_gen - b_gen), 32'd0);
    chk("s3_busy_never", n_busy - b_busy, 32'd0);

    // Pulse stage never acknowledges: timeout exactly 50 cycles into WAIT_G_LO.
    stuck_gen = 1'b1;
    F_START = 32'd5; F_STEP = 32'd1; STEP_NUM = 8'd1; REPEAT = 8'd1;
    snap();
    pulse_start();
    wait_gen("s4_gen_seen", 200);
    repeat (49) @(negedge clk);
    chk("s4_err_before", {30'd0, ERR, BUSY}, 32'd1);
    @(negedge clk);
    chk("s4_err_at", {30'd0, ERR, BUSY}, 32'd2);
    repeat (5) @(negedge clk);
    chk("s4_err_sticky", {31'd0, ERR}, 32'd1);
    chk("s4_no_done", n_done - b_done, 32'd0);
    stuck_gen = 1'b0;
    repeat (3) @(negedge clk);

    // Abort (with a simultaneous START) during SETTLE of the first point, then rerun.
    F_START = 32'd500; F_STEP = 32'd7; STEP_NUM = 8'd2; REPEAT = 8'd1;
    snap();
    pulse_start();
    chk("s5_err_cleared", {31'd0, ERR}, 32'd0);
    repeat (5) @(negedge clk);
    ABORT = 1'b1; START = 1'b1;
    @(negedge clk);
    chk("s5_abort_busy", {31'd0, BUSY}, 32'd0);
    chk("s5_abort_strobes", {30'd0, GEN, FREQW_UPDATE}, 32'd0);
    chk("s5_abort_err", {31'd0, ERR}, 32'd0);
    ABORT = 1'b0; START = 1'b0;
    repeat (20) @(negedge clk);
    chk("s5_no_gen", n_gen - b_gen, 32'd0);
    chk("s5_no_done", n_done - b_done, 32'd0);
    chk("s5_idle_busy", {31'd0, BUSY}, 32'd0);
    snap();
    pulse_start();
    chk("s5_restart_fw", FREQW, 32'd500);
    chk("s5_restart_idx", {24'd0, STEP_IDX}, 32'd0);
    wait_done("s5_done_seen", 1000);
    repeat (3) @(negedge clk);
    chk("s5_fw1", fw_log[(b_upd + 1) % 64], 32'd507);
    chk("s5_done_count", n_done - b_done, 32'd1);

    // Asynchronous reset in WAIT_G_HI, then a normal sweep.
    F_START = 32'd77; F_STEP = 32'd3; STEP_NUM = 8'd3; REPEAT = 8'd2;
    CODE_IN = 32'h1357_9BDF; CODE_LEN_IN = 8'd4; PULSE_LEN_IN = 16'd9;
    snap();
    pulse_start();
    wait_gen("s6_gen_seen", 200);
    repeat (2) @(negedge clk);
    chk("s6_busy_pre", {31'd0, BUSY}, 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    chk("s6_rst_freqw", FREQW, 32'd0);
    chk("s6_rst_flags", {26'd0, GEN, FREQW_UPDATE, BUSY, DONE, ERR, 1'b0}, 32'd0);
    chk("s6_rst_code", CODE, 32'd0);
    chk("s6_rst_lens", {CODE_LEN, PULSE_LEN, STEP_IDX}, 32'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    repeat (10) @(negedge clk);
    chk("s6_no_done", n_done - b_done, 32'd0);
    STEP_NUM = 8'd1; REPEAT = 8'd1;
    snap();
    pulse_start();
    chk("s6_restart_fw", FREQW, 32'd77);
    wait_done("s6_done_seen", 1000);
    repeat (3) @(negedge clk);
    chk("s6_done_count", n_done - b_done, 32'd1);

    chk("strobe_overlap", n_overlap, 32'd0);
    chk("strobe_width", n_wide, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 Parameter SETTLE_CYC, default 100: idle cycles between update-complete and first GEN of a frequency point (0 allowed).
REQ-002 Parameter TIMEOUT_CYC, default 24'd1000000: maximum cycles spent in any wait state.
REQ-003 CLOCK_10M  in  1  system clock, all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 START  in  1  one-cycle request to run a sweep.
REQ-006 ABORT  in  1  stop sweep; has priority over START.
REQ-007 F_START  in  32  first frequency word.
REQ-008 F_STEP  in  32  frequency word increment per point.
REQ-009 STEP_NUM  in  8  number of frequency points.
REQ-010 REPEAT  in  8  pulses per frequency point.
REQ-011 CODE_IN / CODE_LEN_IN / PULSE_LEN_IN  in  32/8/16  pulse shape for the sweep.
REQ-012 FREQW  out  32  frequency word to the signal stage.
REQ-013 FREQW_UPDATE  out  1  one-cycle frequency-load strobe.
REQ-014 FREQW_UPDATE_OVER  in  1  high = frequency load idle/complete.
REQ-015 CODE / CODE_LEN / PULSE_LEN  out  32/8/16  registered pulse shape.
REQ-016 GEN  out  1  one-cycle pulse-fire strobe.
REQ-017 GEN_OVER  in  1  high = pulse generator idle.
REQ-018 BUSY  out  1; DONE  out  1 (one-cycle); ERR  out  1 (sticky); STEP_IDX  out  8 current point index.

Function
REQ-019 States: IDLE, LOAD, WAIT_F_LO, WAIT_F_HI, SETTLE, FIRE, WAIT_G_LO, WAIT_G_HI, NEXT.
REQ-020 IDLE: START sampled high with STEP_NUM>0 and REPEAT>0 -> latch STEP_NUM, REPEAT, F_STEP, CODE_IN, CODE_LEN_IN, PULSE_LEN_IN; FREQW<=F_START; STEP_IDX<=0; clear ERR; BUSY<=1; go LOAD.
REQ-021 IDLE: START with STEP_NUM==0 or REPEAT==0 -> DONE high for exactly one cycle on the next cycle; no FREQW_UPDATE, no GEN, BUSY stays 0.
REQ-022 START while BUSY is ignored; input changes during a sweep do not affect it.
REQ-023 LOAD: FREQW_UPDATE high for one cycle, go WAIT_F_LO.
REQ-024 WAIT_F_LO: wait for FREQW_UPDATE_OVER==0, then WAIT_F_HI; WAIT_F_HI: wait for FREQW_UPDATE_OVER==1, then SETTLE.
REQ-025 SETTLE: count SETTLE_CYC cycles (SETTLE_CYC==0 -> zero extra cycles), then FIRE.
REQ-026 FIRE: GEN high for one cycle only if GEN_OVER==1; otherwise hold in FIRE (timeout applies); then WAIT_G_LO.
REQ-027 WAIT_G_LO: wait GEN_OVER==0; WAIT_G_HI: wait GEN_OVER==1; then decrement per-point pulse counter.
REQ-028 Pulse counter nonzero after decrement -> FIRE (no re-settle); zero -> NEXT.
REQ-029 NEXT: STEP_IDX==STEP_NUM-1 -> DONE one cycle, BUSY<=0, IDLE; else STEP_IDX+1, FREQW<=FREQW+F_STEP (32-bit modulo, wrap silently), reload pulse counter, LOAD.
REQ-030 Timeout counter reset on each state entry; reaching TIMEOUT_CYC in WAIT_F_LO, WAIT_F_HI, FIRE, WAIT_G_LO or WAIT_G_HI -> ERR<=1, BUSY<=0, IDLE, no DONE.
REQ-031 ABORT high in any state -> IDLE next cycle, BUSY<=0, GEN and FREQW_UPDATE 0, no DONE, ERR unchanged; ABORT and START together -> abort wins, sweep not started.
REQ-032 FREQW, CODE, CODE_LEN, PULSE_LEN stable from LOAD until next LOAD/IDLE-start.
REQ-033 GEN and FREQW_UPDATE never high in the same cycle; each strobe exactly one cycle wide.

Reset
REQ-034 RESET_N low -> immediately: state IDLE, FREQW=0, FREQW_UPDATE=0, GEN=0, CODE=0, CODE_LEN=0, PULSE_LEN=0, BUSY=0, DONE=0, ERR=0, STEP_IDX=0, all counters 0.
REQ-035 Reset mid-sweep abandons the sweep with no DONE; first START after release behaves as REQ-020.

Verification
REQ-036 F_START=100, F_STEP=10, STEP_NUM=3, REPEAT=2, SETTLE_CYC=4, model acks -> FREQW 100,110,120; 3 FREQW_UPDATE, 6 GEN, one DONE, ERR=0.
REQ-037 F_START=32'hFFFFFFF8, F_STEP=16, STEP_NUM=2 -> second FREQW=32'h00000008.
REQ-038 STEP_NUM=0 with START -> DONE one cycle later, zero strobes, BUSY never high.
REQ-039 GEN_OVER held high forever after GEN, TIMEOUT_CYC=50 -> ERR=1, BUSY=0 at 50 cycles after WAIT_G_LO entry, no DONE.
REQ-040 ABORT during SETTLE of point 1, then START -> no DONE for first sweep; second sweep restarts at F_START, STEP_IDX=0.
REQ-041 RESET_N pulsed low during WAIT_G_HI -> all outputs at REQ-034 values same cycle; START pulse during BUSY ignored (strobe counts unchanged).
